alu_arbiter: RTL

- Shares one combinational 32-bit ALU between two requesters: requester 0 is the ARM-mode issue lane and requester 1 is the MIPS-mode issue lane.
- Each requester uses a valid/ready handshake. Grants are round-robin, with an optional lock that lets one requester keep the ALU for back-to-back operations.
- The ALU result and Z/N/V flags are captured into a single-entry response register, tagged with the requester ID, and held there under backpressure.

---
 rtl/alu_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin/lockable sharing of one external ALU between two lanes, 1-cycle registered response
module alu_arbiter #(
  parameter int N = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_lock,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_b0,
  input  logic [3:0]   req_op0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b1,
  input  logic [3:0]   req_op1,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_result,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_v,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_z,
  output logic         rsp_n,
  output logic         rsp_v,
  output logic         rsp_err
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic ptr, lock_on, lock_owner, slot_free, locked_gnt, gid, accept, keep;
  logic [CW-1:0] lock_cnt, ncnt;
  always_comb begin
    slot_free = !rsp_valid || rsp_ready;
    locked_gnt = slot_free && lock_on && req_valid[lock_owner];
    gid = locked_gnt ? lock_owner : (ptr ? req_valid[1] : !req_valid[0]);
    accept = rst_n && slot_free && |req_valid;
    req_ready = accept ? (gid ? 2'b10 : 2'b01) : 2'b00;
    alu_a = !accept ? '0 : gid ? req_a1 : req_a0;
    alu_b = !accept ? '0 : gid ? req_b1 : req_b0;
    alu_sel = !accept ? 4'd0 : gid ? req_op1 : req_op0;
    ncnt = locked_gnt ? lock_cnt + 1'b1 : CW'(1);
    keep = req_lock[gid] && ncnt < CW'(LOCK_MAX);
  end
  // Every accept leaves the pointer at !gid; locked grants come from the owner, so it already sits there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_z <= 1'b0;
      rsp_n <= 1'b0;
      rsp_v <= 1'b0;
      rsp_err <= 1'b0;
      ptr <= 1'b0;
      lock_on <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id <= gid;
      rsp_result <= alu_result;
      rsp_z <= alu_z;
      rsp_n <= alu_n;
      rsp_v <= alu_v;
      rsp_err <= alu_sel >= 4'd10;
      ptr <= !gid;
      lock_on <= keep;
      lock_owner <= gid;
      lock_cnt <= keep ? ncnt : '0;
    end else begin
      if (rsp_ready) rsp_valid <= 1'b0;
      if (slot_free) begin
        lock_on <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end
endmodule
